// File: rtl/instr_reg_tx_driver.sv
// Transaction driver for the instruction-register DUT: a DEPTH-entry FIFO
// feeds a small FSM that drives one item per cycle onto registered DUT pins.
// It also supports an inter-item gap, a multi-cycle DUT reset hold, and
// flush/pause control.
module instr_reg_tx_driver #(
    parameter int OP_W     = 32,
    parameter int PTR_W    = 5,
    parameter int OPC_W    = 4,
    parameter int DEPTH    = 8,
    parameter int GAP_W    = 4,
    parameter int RST_HOLD = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       flush,
    input  logic [GAP_W-1:0]           gap_cycles,
    input  logic                       txn_valid,
    output logic                       txn_ready,
    input  logic                       txn_reset_n,
    input  logic                       txn_load_en,
    input  logic [PTR_W-1:0]           txn_read_pointer,
    input  logic [PTR_W-1:0]           txn_write_pointer,
    input  logic [OP_W-1:0]            txn_operand_a,
    input  logic [OP_W-1:0]            txn_operand_b,
    input  logic [OPC_W-1:0]           txn_opcode,
    output logic                       dut_reset_n,
    output logic                       dut_load_en,
    output logic [PTR_W-1:0]           dut_read_pointer,
    output logic [PTR_W-1:0]           dut_write_pointer,
    output logic [OP_W-1:0]            dut_operand_a,
    output logic [OP_W-1:0]            dut_operand_b,
    output logic [OPC_W-1:0]           dut_opcode,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       busy,
    output logic [15:0]                txn_count
);

    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = AW + 1;
    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    localparam int CNT_W  = (GAP_W > HOLD_W) ? GAP_W : HOLD_W;
    localparam int ITEM_W = 2 + 2 * PTR_W + 2 * OP_W + OPC_W;

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_RST, S_GAP} state_t;

    state_t                r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_hold, w_hold_nxt;
    logic [ITEM_W-1:0]     r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [15:0]           r_txn_count;

    logic                  r_dut_reset_n, r_dut_load_en;
    logic [PTR_W-1:0]      r_dut_rp, r_dut_wp;
    logic [OP_W-1:0]       r_dut_a, r_dut_b;
    logic [OPC_W-1:0]      r_dut_opc;

    logic                  w_rn_nxt, w_ld_nxt;
    logic [PTR_W-1:0]      w_rp_nxt, w_wp_nxt;
    logic [OP_W-1:0]       w_a_nxt, w_b_nxt;
    logic [OPC_W-1:0]      w_opc_nxt;

    logic                  w_full, w_push, w_avail, w_pop, w_exit;
    logic [ITEM_W-1:0]     w_wdata, w_head;
    logic                  w_head_rn, w_head_ld;
    logic [PTR_W-1:0]      w_head_rp, w_head_wp;
    logic [OP_W-1:0]       w_head_a, w_head_b;
    logic [OPC_W-1:0]      w_head_opc;

    assign w_full    = (r_count == CW'(DEPTH));
    assign txn_ready = !w_full && !flush;
    assign w_push    = txn_valid && txn_ready;
    assign w_avail   = enable && (r_count != '0) && !flush;

    assign w_wdata = {txn_reset_n, txn_load_en, txn_read_pointer, txn_write_pointer,
                      txn_operand_a, txn_operand_b, txn_opcode};
    assign w_head  = r_mem[r_rd_ptr];
    assign {w_head_rn, w_head_ld, w_head_rp, w_head_wp,
            w_head_a, w_head_b, w_head_opc} = w_head;

    // FSM state and hold/gap counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // Next-state logic; DRIVE and an expired RST share the same exit rule
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_pop       = 1'b0;
        w_exit      = 1'b0;
        case (r_state)
            S_IDLE:  w_pop = w_avail;
            S_DRIVE: w_exit = 1'b1;
            S_RST: begin
                if (r_hold == '0) w_exit = 1'b1;
                else              w_hold_nxt = r_hold - CNT_W'(1);
            end
            S_GAP: begin
                if (r_hold == '0) begin
                    if (w_avail) w_pop = 1'b1;
                    else         w_state_nxt = S_IDLE;
                end else begin
                    w_hold_nxt = r_hold - CNT_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_exit) begin
            if (gap_cycles == '0) begin
                if (w_avail) w_pop = 1'b1;
                else         w_state_nxt = S_IDLE;
            end else begin
                w_state_nxt = S_GAP;
                w_hold_nxt  = CNT_W'(gap_cycles) - CNT_W'(1);
            end
        end
        if (w_pop) begin
            if (w_head_rn) begin
                w_state_nxt = S_DRIVE;
            end else begin
                w_state_nxt = S_RST;
                w_hold_nxt  = CNT_W'(RST_HOLD - 1);
            end
        end
        if (flush) begin
            w_state_nxt = S_IDLE;
            w_pop       = 1'b0;
        end
    end

    // Next pin values: a pop loads the head, leaving an active state releases the pins
    always_comb begin
        w_rn_nxt  = r_dut_reset_n;
        w_ld_nxt  = r_dut_load_en;
        w_rp_nxt  = r_dut_rp;
        w_wp_nxt  = r_dut_wp;
        w_a_nxt   = r_dut_a;
        w_b_nxt   = r_dut_b;
        w_opc_nxt = r_dut_opc;
        if (w_pop) begin
            if (w_head_rn) begin
                w_rn_nxt  = 1'b1;
                w_ld_nxt  = w_head_ld;
                w_rp_nxt  = w_head_rp;
                w_wp_nxt  = w_head_wp;
                w_a_nxt   = w_head_a;
                w_b_nxt   = w_head_b;
                w_opc_nxt = w_head_opc;
            end else begin
                w_rn_nxt = 1'b0;
                w_ld_nxt = 1'b0;
            end
        end else if (flush || r_state != S_IDLE) begin
            // reset_n stays low only while a reset item is still counting down
            w_ld_nxt = 1'b0;
            if (w_state_nxt != S_RST) w_rn_nxt = 1'b1;
        end
    end

    // DUT pin registers and popped-item counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dut_reset_n <= 1'b0;
            r_dut_load_en <= 1'b0;
            r_dut_rp      <= '0;
            r_dut_wp      <= '0;
            r_dut_a       <= '0;
            r_dut_b       <= '0;
            r_dut_opc     <= '0;
            r_txn_count   <= '0;
        end else begin
            r_dut_reset_n <= w_rn_nxt;
            r_dut_load_en <= w_ld_nxt;
            r_dut_rp      <= w_rp_nxt;
            r_dut_wp      <= w_wp_nxt;
            r_dut_a       <= w_a_nxt;
            r_dut_b       <= w_b_nxt;
            r_dut_opc     <= w_opc_nxt;
            if (w_pop) r_txn_count <= r_txn_count + 16'd1;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_wdata;
    end

    assign dut_reset_n       = r_dut_reset_n;
    assign dut_load_en       = r_dut_load_en;
    assign dut_read_pointer  = r_dut_rp;
    assign dut_write_pointer = r_dut_wp;
    assign dut_operand_a     = r_dut_a;
    assign dut_operand_b     = r_dut_b;
    assign dut_opcode        = r_dut_opc;
    assign fifo_count        = r_count;
    assign busy              = (r_state != S_IDLE) || (r_count != '0);
    assign txn_count         = r_txn_count;

endmodule

// File: tb/tb_instr_reg_tx_driver.sv
// Self-checking bench for instr_reg_tx_driver: a scoreboard of pushed load
// items checked against the pins, a table of single-item vectors, and
// hand-written sequences for gap, reset hold, fill, flush, reset and wrap.
module tb_instr_reg_tx_driver;

    typedef struct packed {
        logic        rn;
        logic        ld;
        logic [4:0]  rp;
        logic [4:0]  wp;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  opc;
    } item_t;

    typedef struct {
        item_t       it;
        logic        e_ld;
        logic        e_rn;
        logic [4:0]  e_rp;
        logic [4:0]  e_wp;
        logic [31:0] e_a;
        logic [31:0] e_b;
        logic [3:0]  e_opc;
        logic [15:0] e_tc;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, enable, flush, txn_valid, txn_ready;
    logic [3:0]  gap_cycles;
    logic        txn_reset_n, txn_load_en;
    logic [4:0]  txn_read_pointer, txn_write_pointer;
    logic [31:0] txn_operand_a, txn_operand_b;
    logic [3:0]  txn_opcode;
    logic        dut_reset_n, dut_load_en;
    logic [4:0]  dut_read_pointer, dut_write_pointer;
    logic [31:0] dut_operand_a, dut_operand_b;
    logic [3:0]  dut_opcode;
    logic [3:0]  fifo_count;
    logic        busy;
    logic [15:0] txn_count;

    int    n_vec = 0;
    int    n_err = 0;
    int    n_drv = 0;
    item_t sb [$];
    item_t m_exp;
    logic  ld_h [16];
    logic  rn_h [16];
    logic [3:0] op_h [16];
    vec_t  tbl [4];
    logic  rdy_s;
    logic [15:0] pat;
    int    base_drv, accepted, guard;
    logic  seen_ffff;
    logic [15:0] tc_before;

    instr_reg_tx_driver #(
        .OP_W(32), .PTR_W(5), .OPC_W(4), .DEPTH(8), .GAP_W(4), .RST_HOLD(2)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush),
        .gap_cycles(gap_cycles), .txn_valid(txn_valid), .txn_ready(txn_ready),
        .txn_reset_n(txn_reset_n), .txn_load_en(txn_load_en),
        .txn_read_pointer(txn_read_pointer), .txn_write_pointer(txn_write_pointer),
        .txn_operand_a(txn_operand_a), .txn_operand_b(txn_operand_b),
        .txn_opcode(txn_opcode),
        .dut_reset_n(dut_reset_n), .dut_load_en(dut_load_en),
        .dut_read_pointer(dut_read_pointer), .dut_write_pointer(dut_write_pointer),
        .dut_operand_a(dut_operand_a), .dut_operand_b(dut_operand_b),
        .dut_opcode(dut_opcode), .fifo_count(fifo_count), .busy(busy),
        .txn_count(txn_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic item_t mk(input logic rn, input logic ld, input logic [4:0] rp,
                                 input logic [4:0] wp, input logic [31:0] a,
                                 input logic [31:0] b, input logic [3:0] opc);
        item_t t;
        t.rn = rn; t.ld = ld; t.rp = rp; t.wp = wp; t.a = a; t.b = b; t.opc = opc;
        return t;
    endfunction

    task automatic drive(input item_t it);
        txn_reset_n       = it.rn;
        txn_load_en       = it.ld;
        txn_read_pointer  = it.rp;
        txn_write_pointer = it.wp;
        txn_operand_a     = it.a;
        txn_operand_b     = it.b;
        txn_opcode        = it.opc;
        txn_valid         = 1'b1;
    endtask

    // Present an item and hold it until accepted; returns on the negedge after acceptance
    task automatic push(input item_t it);
        logic r;
        int   k;
        r = 1'b0;
        k = 0;
        @(negedge clk);
        drive(it);
        while (!r && k < 200) begin
            #1 r = txn_ready;
            @(negedge clk);
            k++;
        end
        txn_valid = 1'b0;
        chk("push_accepted", r, 1);
        if (r && it.rn && it.ld) sb.push_back(it);
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ld_h[i] = dut_load_en;
            rn_h[i] = dut_reset_n;
            op_h[i] = dut_opcode;
        end
    endtask

    task automatic wait_idle(input int max);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < max) begin
            @(negedge clk);
            k++;
        end
        chk("idle_within_bound", busy, 0);
    endtask

    // Scoreboard: every cycle with load_en high must match the oldest pushed load item
    always @(negedge clk) begin
        if (reset === 1'b0 && dut_load_en === 1'b1) begin
            n_drv++;
            chk("sb_has_item", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                m_exp = sb.pop_front();
                chk("sb_rp",  dut_read_pointer,  m_exp.rp);
                chk("sb_wp",  dut_write_pointer, m_exp.wp);
                chk("sb_a",   dut_operand_a,     m_exp.a);
                chk("sb_b",   dut_operand_b,     m_exp.b);
                chk("sb_opc", dut_opcode,        m_exp.opc);
                chk("sb_rn",  dut_reset_n,       1);
            end
        end
    end

    initial begin
        tbl[0] = '{mk(1, 1, 5'd1, 5'd9, 32'hDEADBEEF, 32'h12345678, 4'hA),
                   1'b1, 1'b1, 5'd1, 5'd9, 32'hDEADBEEF, 32'h12345678, 4'hA, 16'd2};
        tbl[1] = '{mk(1, 0, 5'd31, 5'd0, 32'hFFFFFFFF, 32'h0, 4'hF),
                   1'b0, 1'b1, 5'd31, 5'd0, 32'hFFFFFFFF, 32'h0, 4'hF, 16'd3};
        tbl[2] = '{mk(0, 1, 5'd7, 5'd7, 32'h1, 32'h2, 4'h5),
                   1'b0, 1'b0, 5'd31, 5'd0, 32'hFFFFFFFF, 32'h0, 4'hF, 16'd4};
        tbl[3] = '{mk(1, 1, 5'd3, 5'd4, 32'h80000000, 32'h7FFFFFFF, 4'h0),
                   1'b1, 1'b1, 5'd3, 5'd4, 32'h80000000, 32'h7FFFFFFF, 4'h0, 16'd5};

        reset = 1'b1; enable = 1'b1; flush = 1'b0; gap_cycles = '0;
        txn_valid = 1'b0; txn_reset_n = 1'b1; txn_load_en = 1'b0;
        txn_read_pointer = '0; txn_write_pointer = '0;
        txn_operand_a = '0; txn_operand_b = '0; txn_opcode = '0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_dut_reset_n", dut_reset_n, 0);
        chk("rst_load_en", dut_load_en, 0);
        chk("rst_rp", dut_read_pointer, 0);
        chk("rst_wp", dut_write_pointer, 0);
        chk("rst_a", dut_operand_a, 0);
        chk("rst_b", dut_operand_b, 0);
        chk("rst_opc", dut_opcode, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_txn_count", txn_count, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", txn_ready, 1);

        // Single item: latency and one-cycle load pulse
        push(mk(1, 1, 5'd0, 5'd2, 32'd5, 32'd7, 4'd3));
        chk("t1_count_after_push", fifo_count, 1);
        @(negedge clk);
        chk("t1_load_en", dut_load_en, 1);
        chk("t1_reset_n", dut_reset_n, 1);
        chk("t1_txn_count", txn_count, 1);
        chk("t1_fifo_empty", fifo_count, 0);
        @(negedge clk);
        chk("t1_load_pulse_end", dut_load_en, 0);

        // Table of single-item vectors
        for (int i = 0; i < 4; i++) begin
            push(tbl[i].it);
            @(negedge clk);
            chk("tbl_ld",  dut_load_en,       tbl[i].e_ld);
            chk("tbl_rn",  dut_reset_n,       tbl[i].e_rn);
            chk("tbl_rp",  dut_read_pointer,  tbl[i].e_rp);
            chk("tbl_wp",  dut_write_pointer, tbl[i].e_wp);
            chk("tbl_a",   dut_operand_a,     tbl[i].e_a);
            chk("tbl_b",   dut_operand_b,     tbl[i].e_b);
            chk("tbl_opc", dut_opcode,        tbl[i].e_opc);
            chk("tbl_tc",  txn_count,         tbl[i].e_tc);
            repeat (3) @(negedge clk);
        end

        // Four back-to-back items, no gap
        enable = 1'b0;
        for (int i = 0; i < 4; i++)
            push(mk(1, 1, 5'(i), 5'(i + 10), 32'h1000 + i, 32'h2000 - i, 4'(i + 1)));
        enable = 1'b1;
        capture(8);
        pat = '0;
        for (int i = 0; i < 8; i++) pat = {pat[14:0], ld_h[i]};
        chk("b2b_load_pattern", pat, 16'b1111_0000);
        chk("b2b_tc", txn_count, 9);

        // Three items with a 3-cycle gap
        gap_cycles = 4'd3;
        enable = 1'b0;
        for (int i = 0; i < 3; i++)
            push(mk(1, 1, 5'(i + 20), 5'(i), 32'hA0 + i, 32'hB0 + i, 4'(i + 8)));
        enable = 1'b1;
        capture(13);
        pat = '0;
        for (int i = 0; i < 13; i++) pat = {pat[14:0], ld_h[i]};
        chk("gap3_load_pattern", pat, 16'b1_0001_0001_0000);
        wait_idle(20);
        chk("gap3_tc", txn_count, 12);
        gap_cycles = '0;

        // Reset item between two normal items
        enable = 1'b0;
        push(mk(1, 1, 5'd1, 5'd2, 32'h66, 32'h77, 4'h6));
        push(mk(0, 1, 5'd9, 5'd9, 32'h99, 32'h99, 4'h9));
        push(mk(1, 1, 5'd3, 5'd4, 32'hCC, 32'hDD, 4'hC));
        enable = 1'b1;
        capture(5);
        pat = '0;
        for (int i = 0; i < 5; i++) pat = {pat[14:0], ld_h[i]};
        chk("rsti_load_pattern", pat, 16'b10010);
        pat = '0;
        for (int i = 0; i < 5; i++) pat = {pat[14:0], rn_h[i]};
        chk("rsti_reset_n_pattern", pat, 16'b10011);
        chk("rsti_opc_hold0", op_h[1], 4'h6);
        chk("rsti_opc_hold1", op_h[2], 4'h6);
        chk("rsti_next_opc", op_h[3], 4'hC);
        chk("rsti_tc", txn_count, 15);

        // Fill FIFO while paused, hold a ninth item, then drain
        enable = 1'b0;
        base_drv = n_drv;
        for (int i = 0; i < 8; i++)
            push(mk(1, 1, 5'(i), 5'(7 - i), 32'h100 + i, ~(32'h100 + i), 4'(i)));
        chk("fill_count_full", fifo_count, 8);
        drive(mk(1, 1, 5'd17, 5'd18, 32'h900, 32'h901, 4'hE));
        #1 chk("fill_ready_low", txn_ready, 0);
        @(negedge clk);
        chk("fill_not_accepted", fifo_count, 8);
        enable = 1'b1;
        push(mk(1, 1, 5'd17, 5'd18, 32'h900, 32'h901, 4'hE));
        wait_idle(100);
        chk("fill_all_driven", n_drv - base_drv, 9);
        chk("fill_tc", txn_count, 24);

        // Flush during a gap with five items queued
        gap_cycles = 4'd3;
        enable = 1'b0;
        for (int i = 0; i < 6; i++)
            push(mk(1, 1, 5'(i + 2), 5'(i + 3), 32'h5000 + i, 32'h6000 + i, 4'(i + 2)));
        base_drv = n_drv;
        enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("flush_pre_count", fifo_count, 5);
        tc_before = txn_count;
        flush = 1'b1;
        drive(mk(1, 1, 5'd30, 5'd30, 32'hF00D, 32'hF00D, 4'hF));
        #1 chk("flush_ready_low", txn_ready, 0);
        @(negedge clk);
        flush = 1'b0;
        txn_valid = 1'b0;
        sb.delete();
        chk("flush_count", fifo_count, 0);
        chk("flush_busy", busy, 0);
        chk("flush_load_en", dut_load_en, 0);
        chk("flush_reset_n", dut_reset_n, 1);
        chk("flush_tc_unchanged", txn_count, tc_before);
        chk("flush_tc", txn_count, 25);
        repeat (10) @(negedge clk);
        chk("flush_no_more_items", n_drv - base_drv, 1);
        chk("flush_count_stays", fifo_count, 0);
        gap_cycles = '0;

        // Block reset while a reset item is holding
        enable = 1'b0;
        push(mk(0, 0, 5'd1, 5'd1, 32'h1, 32'h1, 4'h1));
        push(mk(1, 1, 5'd2, 5'd2, 32'h2, 32'h2, 4'h2));
        enable = 1'b1;
        @(negedge clk);
        chk("midrst_in_rst", dut_reset_n, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_reset_n", dut_reset_n, 0);
        chk("midrst_load_en", dut_load_en, 0);
        chk("midrst_count", fifo_count, 0);
        chk("midrst_tc", txn_count, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_opc", dut_opcode, 0);
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("midrst_idle_after", busy, 0);

        // 65536 pops wrap txn_count to zero
        @(negedge clk);
        drive(mk(1, 0, 5'd0, 5'd0, 32'h0, 32'h0, 4'h0));
        accepted = 0;
        guard = 0;
        seen_ffff = 1'b0;
        while (accepted < 65536 && guard < 70000) begin
            #1 rdy_s = txn_ready;
            @(negedge clk);
            guard++;
            if (rdy_s) accepted++;
            if (txn_count == 16'hFFFF) seen_ffff = 1'b1;
            if (accepted == 65536) txn_valid = 1'b0;
        end
        txn_valid = 1'b0;
        chk("wrap_accepted", accepted, 65536);
        wait_idle(20);
        chk("wrap_seen_ffff", seen_ffff, 1);
        chk("wrap_tc_zero", txn_count, 0);

        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
